// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a multicycle MIPS-style datapath with a
//   ready-handshaked memory.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   0     | FETCH   read instruction at PC, PC <= PC+4 when memory ready
//   1     | DECODE  compute branch target into ALUOut, dispatch on op_code
//   2     | MEMADR  effective address for lw/sw
//   3     | MEMRD   data read, waits on mem_ready
//   4     | MEMWB   load result into register file
//   5     | MEMWR   data write, waits on mem_ready
//   6     | REX     R-type execute, operation from funct
//   7     | ALUWB   R-type result into register file
//   8     | BEQ     compare, PC <= ALUOut when Zero
//   9     | ADDIEX  rs + immediate
//   10    | ADDIWB  addi result into register file
//   11    | JUMP    PC <= jump target
//   12    | BNE     compare, PC <= ALUOut when not Zero
//   13-15 | unused, behave like FETCH without strobes, recover to FETCH
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   op_code, funct      instruction fields from the instruction register
//   Zero, mem_ready     ALU zero flag, memory access-complete handshake
//   IorD .. PCSrc       datapath control signals
//   pc_en               PC load enable (PCWrite or taken branch)
//   state               current state code
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       pc_en,
    output logic [3:0] state
);

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_REX    = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BEQ    = 4'd8;
    localparam logic [3:0] ST_ADDIEX = 4'd9;
    localparam logic [3:0] ST_ADDIWB = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_BNE    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic [3:0] next_state;
    logic [3:0] out_state;
    logic       pc_write;
    logic       branch_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_FETCH;
        case (state)
            ST_FETCH:  next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op_code)
                    OP_RTYPE:     next_state = ST_REX;
                    OP_LW, OP_SW: next_state = ST_MEMADR;
                    OP_BEQ:       next_state = ST_BEQ;
                    OP_BNE:       next_state = ST_BNE;
                    OP_ADDI:      next_state = ST_ADDIEX;
                    OP_J:         next_state = ST_JUMP;
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR: next_state = (op_code == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  next_state = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_REX:    next_state = ST_ALUWB;
            ST_ADDIEX: next_state = ST_ADDIWB;
            default:   next_state = ST_FETCH;
        endcase
    end

    // Reset makes the outputs look like FETCH regardless of the held state;
    // the strobes are then cleared separately below.
    assign out_state = reset ? ST_FETCH : state;

    always_comb begin
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        PCSrc       = 2'b00;
        pc_write    = 1'b0;
        branch_take = 1'b0;
        case (out_state)
            ST_DECODE: ALUSrcB = 2'b11;
            ST_MEMADR, ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            ST_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_REX: begin
                ALUSrcA = 1'b1;
                case (funct)
                    6'b100000: ALUControl = ALU_ADD;
                    6'b100010: ALUControl = ALU_SUB;
                    6'b100100: ALUControl = ALU_AND;
                    6'b100101: ALUControl = ALU_OR;
                    6'b101010: ALUControl = ALU_SLT;
                    6'b100111: ALUControl = ALU_NOR;
                    default:   ALUControl = ALU_ADD;
                endcase
            end
            ST_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                ALUSrcA     = 1'b1;
                ALUControl  = ALU_SUB;
                PCSrc       = 2'b01;
                branch_take = (out_state == ST_BEQ) ? Zero : ~Zero;
            end
            ST_ADDIWB: RegWrite = 1'b1;
            ST_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                // FETCH, and the unused codes which fetch-look but never load
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (out_state == ST_FETCH && !reset) begin
                    IRWrite  = mem_ready;
                    pc_write = mem_ready;
                end
            end
        endcase
        pc_en = pc_write | branch_take;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                   S_MEMWB = 4, S_MEMWR = 5, S_REX = 6, S_ALUWB = 7,
                   S_BEQ = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11,
                   S_BNE = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op_code = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl, state;
    logic       pc_en;

    int passed = 0;
    int total  = 0;
    int m_st   = S_FETCH;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op_code(op_code), .funct(funct),
        .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .PCSrc(PCSrc), .pc_en(pc_en), .state(state)
    );

    always #5 clk = ~clk;

    wire [20:0] dut_vec = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                           RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, pc_en, state};

    function automatic logic [3:0] alu_of(logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0010;
        endcase
    endfunction

    // Expected outputs from the per-state output lists, reset override and pc_en rule.
    function automatic logic [20:0] model_out(int st, bit rst, bit rdy, bit z, logic [5:0] fn);
        bit iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, srca = 0, pcw = 0, pcen;
        logic [1:0] srcb = 2'b00, pcs = 2'b00;
        logic [3:0] alu = 4'b0010;
        logic [3:0] st4;
        int eff;
        eff = rst ? S_FETCH : st;
        if (eff == S_FETCH || eff > 12) begin
            mrd = 1; srcb = 2'b01;
            if (eff == S_FETCH && !rst) begin irw = rdy; pcw = rdy; end
        end
        else if (eff == S_DECODE) srcb = 2'b11;
        else if (eff == S_MEMADR || eff == S_ADDIEX) begin srca = 1; srcb = 2'b10; end
        else if (eff == S_MEMRD) begin iord = 1; mrd = 1; end
        else if (eff == S_MEMWB) begin m2r = 1; rw = 1; end
        else if (eff == S_MEMWR) begin iord = 1; mwr = 1; end
        else if (eff == S_REX) begin srca = 1; alu = alu_of(fn); end
        else if (eff == S_ALUWB) begin rdst = 1; rw = 1; end
        else if (eff == S_BEQ || eff == S_BNE) begin srca = 1; alu = 4'b0110; pcs = 2'b01; end
        else if (eff == S_ADDIWB) rw = 1;
        else if (eff == S_JUMP) begin pcs = 2'b10; pcw = 1; end
        pcen = pcw || (eff == S_BEQ && z) || (eff == S_BNE && !z);
        st4 = 4'(st);
        return {iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, alu, pcs, pcen, st4};
    endfunction

    function automatic int model_next(int st, bit rst, bit rdy, logic [5:0] op);
        if (rst) return S_FETCH;
        if (st == S_FETCH) return rdy ? S_DECODE : S_FETCH;
        if (st == S_DECODE) begin
            if (op == 6'b000000) return S_REX;
            if (op == 6'b100011 || op == 6'b101011) return S_MEMADR;
            if (op == 6'b000100) return S_BEQ;
            if (op == 6'b000101) return S_BNE;
            if (op == 6'b001000) return S_ADDIEX;
            if (op == 6'b000010) return S_JUMP;
            return S_FETCH;
        end
        if (st == S_MEMADR) return (op == 6'b100011) ? S_MEMRD : S_MEMWR;
        if (st == S_MEMRD) return rdy ? S_MEMWB : S_MEMRD;
        if (st == S_MEMWR) return rdy ? S_FETCH : S_MEMWR;
        if (st == S_REX) return S_ALUWB;
        if (st == S_ADDIEX) return S_ADDIWB;
        return S_FETCH;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: drive inputs just after the edge, compare against the model mid-cycle.
    task automatic step(bit r, bit rdy, bit z, logic [5:0] op, logic [5:0] fn, string name);
        @(posedge clk);
        #1;
        reset = r; mem_ready = rdy; Zero = z; op_code = op; funct = fn;
        @(negedge clk);
        check(name, {11'd0, dut_vec}, {11'd0, model_out(m_st, r, rdy, z, fn)});
        m_st = model_next(m_st, r, rdy, op);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         z;
        int         cycles;
        logic [3:0] exec_alu;
        bit         exec_pcen;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n, mw_run, mw_max;
        bit captured, rw_seen;
        logic [3:0] cap_alu;
        logic cap_pc;
        logic [5:0] ops[8];
        logic [5:0] fns[7];
        bit rdy_pat[8];

        vecs[0]  = '{6'b100011, 6'b000000, 0, 5, 4'b0010, 0};
        vecs[1]  = '{6'b101011, 6'b000000, 0, 4, 4'b0010, 0};
        vecs[2]  = '{6'b000000, 6'b100000, 0, 4, 4'b0010, 0};
        vecs[3]  = '{6'b000000, 6'b100010, 0, 4, 4'b0110, 0};
        vecs[4]  = '{6'b000000, 6'b100100, 1, 4, 4'b0000, 0};
        vecs[5]  = '{6'b000000, 6'b100101, 0, 4, 4'b0001, 0};
        vecs[6]  = '{6'b000000, 6'b101010, 0, 4, 4'b0111, 0};
        vecs[7]  = '{6'b000000, 6'b100111, 0, 4, 4'b1100, 0};
        vecs[8]  = '{6'b000000, 6'b111111, 0, 4, 4'b0010, 0};
        vecs[9]  = '{6'b001000, 6'b000000, 0, 4, 4'b0010, 0};
        vecs[10] = '{6'b000100, 6'b000000, 1, 3, 4'b0110, 1};
        vecs[11] = '{6'b000100, 6'b000000, 0, 3, 4'b0110, 0};
        vecs[12] = '{6'b000101, 6'b000000, 1, 3, 4'b0110, 0};
        vecs[13] = '{6'b000101, 6'b000000, 0, 3, 4'b0110, 1};
        vecs[14] = '{6'b000010, 6'b000000, 0, 3, 4'b0010, 1};
        vecs[15] = '{6'b111111, 6'b000000, 0, 2, 4'b0010, 0};

        // power-up: hold reset across a first edge so the model knows the state
        @(posedge clk);
        #1;
        m_st = S_FETCH;
        step(1, 1, 0, 6'b100011, 6'd0, "reset_hold");
        check("reset_state", {28'd0, state}, 32'd0);

        foreach (vecs[i]) begin
            step(1, 1, vecs[i].z, vecs[i].op, vecs[i].fn, "vec_reset");
            n = 0; captured = 0; cap_alu = 4'b0010; cap_pc = 0;
            for (int k = 0; k < 12; k++) begin
                step(0, 1, vecs[i].z, vecs[i].op, vecs[i].fn, "vec_cycle");
                if (k > 0 && state == 4'd0) break;
                n++;
                if (k == 2) begin captured = 1; cap_alu = ALUControl; cap_pc = pc_en; end
            end
            check($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
            if (captured) begin
                check($sformatf("vec%0d_exec_alu", i), {28'd0, cap_alu}, {28'd0, vecs[i].exec_alu});
                check($sformatf("vec%0d_exec_pcen", i), {31'd0, cap_pc}, {31'd0, vecs[i].exec_pcen});
            end
        end

        // sw with memory stalling three cycles in MEMWR
        rdy_pat = '{1, 1, 1, 0, 0, 0, 1, 1};
        step(1, 1, 0, 6'b101011, 6'd0, "sw_reset");
        mw_run = 0; mw_max = 0; rw_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, rdy_pat[k], 0, 6'b101011, 6'd0, "sw_stall");
            if (MemWrite) mw_run++; else mw_run = 0;
            if (mw_run > mw_max) mw_max = mw_run;
            if (RegWrite) rw_seen = 1;
        end
        check("sw_memwrite_run", mw_max, 4);
        check("sw_regwrite_seen", {31'd0, rw_seen}, 32'd0);
        check("sw_end_state", {28'd0, state}, 32'd0);

        // reset while waiting in MEMRD
        step(1, 1, 0, 6'b100011, 6'd0, "lw_reset");
        step(0, 1, 0, 6'b100011, 6'd0, "lw_fetch");
        step(0, 1, 0, 6'b100011, 6'd0, "lw_decode");
        step(0, 1, 0, 6'b100011, 6'd0, "lw_memadr");
        step(0, 0, 0, 6'b100011, 6'd0, "lw_memrd_wait");
        check("memrd_wait_state", {28'd0, state}, 32'd3);
        step(1, 0, 1, 6'b100011, 6'd0, "memrd_reset");
        check("reset_strobes", {28'd0, pc_en, RegWrite, MemWrite, IRWrite}, 32'd0);
        step(1, 1, 1, 6'b100011, 6'd0, "reset_second");
        check("reset_to_fetch", {28'd0, state}, 32'd0);
        check("reset_strobes2", {28'd0, pc_en, RegWrite, MemWrite, IRWrite}, 32'd0);
        step(0, 1, 0, 6'b100011, 6'd0, "first_fetch");
        check("first_fetch_issue", {29'd0, MemRead, IRWrite, pc_en}, 32'h7);

        // illegal opcode: DECODE issues no strobe
        step(1, 1, 0, 6'b111111, 6'd0, "ill_reset");
        step(0, 1, 0, 6'b111111, 6'd0, "ill_fetch");
        step(0, 1, 0, 6'b111111, 6'd0, "ill_decode");
        check("ill_decode_strobes", {27'd0, pc_en, RegWrite, MemWrite, IRWrite, state == 4'd1}, 32'd1);
        step(0, 1, 0, 6'b111111, 6'd0, "ill_back");
        check("ill_back_state", {28'd0, state}, 32'd0);

        // random traffic against the model
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                6'b001000, 6'b000010, 6'b110011};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                6'b100111, 6'b010101};
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 ops[$urandom_range(0, 7)], fns[$urandom_range(0, 6)], "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
